// File: rtl/spi_mem_pkg.sv
// Shared state encoding, opcodes and frame geometry for the SPI data-memory controller.
package spi_mem_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_GAP   = 2'd2
   } state_t;

   localparam logic [7:0] CMD_READ_DEF  = 8'h03;
   localparam logic [7:0] CMD_WRITE_DEF = 8'h02;
   localparam int         FRAME_BITS    = 64;
   localparam int         DATA_BITS     = 32;

   // The serial data field carries byte 0 first, so words cross the wire byte-reversed.
   function automatic logic [DATA_BITS-1:0] byte_swap32(input logic [DATA_BITS-1:0] w);
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
   endfunction

endpackage

// File: rtl/spi_sck_gen.sv
// Mode-0 SCK generator: CLK_DIV clk cycles per half-period, with strobes on the edges
// that will raise and lower SCK. Held idle (SCK low, counter cleared) while disabled.
module spi_sck_gen #(
   parameter int CLK_DIV = 2
) (
   input  logic clk,
   input  logic reset,
   input  logic enable,
   output logic sck,
   output logic rise,
   output logic fall
);

   localparam int                DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DIV_W-1:0]  DIV_LAST = DIV_W'(CLK_DIV - 1);

   logic [DIV_W-1:0] div_cnt;
   logic             phase_end;

   assign phase_end = enable && (div_cnt == DIV_LAST);
   assign rise      = phase_end && !sck;
   assign fall      = phase_end && sck;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         div_cnt <= '0;
         sck     <= 1'b0;
      end else if (!enable) begin
         div_cnt <= '0;
         sck     <= 1'b0;
      end else if (phase_end) begin
         div_cnt <= '0;
         sck     <= ~sck;
      end else begin
         div_cnt <= div_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/spi_mem_controller.sv
// Runs one 64-bit Mode-0 SPI frame (cmd, 24-bit addr, 32-bit data) per load/store
// request against a serial SRAM, stalling the core until the response pulse.
module spi_mem_controller
   import spi_mem_pkg::*;
#(
   parameter int         CLK_DIV   = 2,
   parameter int         CS_GAP    = 2,
   parameter logic [7:0] CMD_READ  = CMD_READ_DEF,
   parameter logic [7:0] CMD_WRITE = CMD_WRITE_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [23:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        busy,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        spi_cs,
   output logic        spi_sck,
   output logic        spi_mosi,
   input  logic        spi_miso
);

   localparam int             GAP_W      = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);
   localparam logic [5:0]     BIT_LAST   = 6'(FRAME_BITS - 1);
   localparam logic [5:0]     DATA_FIRST = 6'(FRAME_BITS - DATA_BITS);

   state_t                  state_q, state_d;
   logic [5:0]              bitcnt_q;
   logic [GAP_W-1:0]        gap_cnt_q;
   logic [FRAME_BITS-1:0]   tx_q;
   logic [DATA_BITS-1:0]    rx_q;
   logic                    is_write_q;
   logic                    accept;
   logic                    sck_rise, sck_fall;
   logic                    last_fall;
   logic [FRAME_BITS-1:0]   frame;

   assign req_ready = (state_q == ST_IDLE);
   assign busy      = ~req_ready;
   assign accept    = req_ready && req_valid;
   assign last_fall = sck_fall && (bitcnt_q == BIT_LAST);
   assign frame     = {(req_write ? CMD_WRITE : CMD_READ), req_addr,
                       (req_write ? byte_swap32(req_wdata) : {DATA_BITS{1'b0}})};

   spi_sck_gen #(
      .CLK_DIV (CLK_DIV)
   ) u_sck_gen (
      .clk    (clk),
      .reset  (reset),
      .enable (state_q == ST_SHIFT),
      .sck    (spi_sck),
      .rise   (sck_rise),
      .fall   (sck_fall)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state_q <= ST_IDLE;
      else       state_q <= state_d;
   end

   // NOTE: state_d gets its default before the case, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (req_valid)                state_d = ST_SHIFT;
         ST_SHIFT: if (last_fall)                state_d = ST_GAP;
         ST_GAP:   if (gap_cnt_q == GAP_LAST)    state_d = ST_IDLE;
         default:                                state_d = ST_IDLE;
      endcase
   end

   // NOTE: non-blocking assignments here so every flop samples the values from before the edge.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bitcnt_q   <= '0;
         gap_cnt_q  <= '0;
         tx_q       <= '0;
         rx_q       <= '0;
         is_write_q <= 1'b0;
         spi_cs     <= 1'b1;
         spi_mosi   <= 1'b0;
         resp_valid <= 1'b0;
         resp_rdata <= '0;
      end else begin
         resp_valid <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (accept) begin
                  tx_q       <= frame;
                  spi_mosi   <= frame[FRAME_BITS-1];
                  spi_cs     <= 1'b0;
                  bitcnt_q   <= '0;
                  rx_q       <= '0;
                  is_write_q <= req_write;
               end
            end
            ST_SHIFT: begin
               if (sck_rise && (bitcnt_q >= DATA_FIRST))
                  rx_q <= {rx_q[DATA_BITS-2:0], spi_miso};
               if (last_fall) begin
                  spi_cs     <= 1'b1;
                  spi_mosi   <= 1'b0;
                  resp_valid <= 1'b1;
                  gap_cnt_q  <= '0;
                  if (!is_write_q)
                     resp_rdata <= byte_swap32(rx_q);
               end else if (sck_fall) begin
                  bitcnt_q <= bitcnt_q + 6'd1;
                  tx_q     <= {tx_q[FRAME_BITS-2:0], 1'b0};
                  spi_mosi <= tx_q[FRAME_BITS-2];
               end
            end
            ST_GAP: begin
               gap_cnt_q <= gap_cnt_q + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_spi_mem_controller.sv
// Self-checking bench: behavioural serial SRAM on the pins, fixed vectors, hand-written
// corner sequences and random traffic checked against a byte-array reference memory.
module tb_spi_mem_controller;

   localparam int CLK_DIV = 2;
   localparam int CS_GAP  = 2;
   localparam int LAT     = 64 * 2 * CLK_DIV + 1;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, req_write;
   logic [23:0] req_addr;
   logic [31:0] req_wdata;
   logic        req_ready, busy, resp_valid;
   logic [31:0] resp_rdata;
   logic        spi_cs, spi_sck, spi_mosi;
   logic        spi_miso = 1'b0;

   int n_vec = 0;
   int n_bad = 0;
   int cyc   = 0;

   spi_mem_controller #(.CLK_DIV(CLK_DIV), .CS_GAP(CS_GAP)) dut (
      .clk        (clk),
      .reset      (reset),
      .req_valid  (req_valid),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .req_ready  (req_ready),
      .busy       (busy),
      .resp_valid (resp_valid),
      .resp_rdata (resp_rdata),
      .spi_cs     (spi_cs),
      .spi_sck    (spi_sck),
      .spi_mosi   (spi_mosi),
      .spi_miso   (spi_miso)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   // ---------------- behavioural serial SRAM ----------------
   typedef struct { logic [63:0] bits; int nsck; } frame_t;

   logic [7:0]  sram [bit [23:0]];
   logic [7:0]  ref_mem [bit [23:0]];
   frame_t      frames [$];
   logic [63:0] cap;
   logic [7:0]  cmd_r;
   logic [23:0] addr_r;
   logic [7:0]  rd_byte;
   int          nbits = 0;
   int          sck_cs_viol = 0;
   bit          in_frame = 0;

   function automatic logic [7:0] sram_rd(input bit [23:0] a);
      return sram.exists(a) ? sram[a] : 8'h00;
   endfunction

   function automatic logic [7:0] ref_rd(input bit [23:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : 8'h00;
   endfunction

   always @(negedge spi_cs) begin
      cap = '0; nbits = 0; cmd_r = '0; addr_r = '0; in_frame = 1;
   end

   always @(posedge spi_cs) begin
      if (in_frame) frames.push_back('{cap, nbits});
      in_frame = 0;
   end

   always @(posedge spi_sck) begin
      if (spi_cs) sck_cs_viol++;
      else begin
         cap = {cap[62:0], spi_mosi};
         nbits++;
         if (nbits == 8)  cmd_r  = cap[7:0];
         if (nbits == 32) addr_r = cap[23:0];
         if (nbits > 32 && nbits % 8 == 0 && cmd_r == 8'h02)
            sram[addr_r + 24'((nbits - 40) / 8)] = cap[7:0];
      end
   end

   always @(negedge spi_sck) begin
      if (!spi_cs && cmd_r == 8'h03 && nbits >= 32 && nbits < 64) begin
         rd_byte  = sram_rd(addr_r + 24'((nbits - 32) / 8));
         spi_miso = rd_byte[7 - (nbits - 32) % 8];
      end
   end

   // ---------------- reference model helpers ----------------
   function automatic logic [63:0] exp_frame(input bit wr, input logic [23:0] a, input logic [31:0] wd);
      logic [31:0] data = 0;
      if (wr) for (int k = 0; k < 4; k++) data = (data << 8) | ((wd >> (8 * k)) & 32'hFF);
      return {(wr ? 8'h02 : 8'h03), a, data};
   endfunction

   function automatic logic [31:0] ref_load(input logic [23:0] a);
      logic [31:0] w = 0;
      for (int k = 0; k < 4; k++) w = w | (32'(ref_rd(a + 24'(k))) << (8 * k));
      return w;
   endfunction

   task automatic ref_store(input logic [23:0] a, input logic [31:0] wd);
      for (int k = 0; k < 4; k++) ref_mem[a + 24'(k)] = 8'((wd >> (8 * k)) & 32'hFF);
   endtask

   task automatic preload(input logic [23:0] a, input logic [31:0] wd);
      ref_store(a, wd);
      for (int k = 0; k < 4; k++) sram[a + 24'(k)] = 8'((wd >> (8 * k)) & 32'hFF);
   endtask

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_ready();
      int t = 0;
      while (!req_ready && t < 2000) begin @(negedge clk); t++; end
      if (!req_ready) check("ready_timeout", 0, 1);
   endtask

   // One complete transaction; called and returns on a falling clk edge.
   task automatic run_txn(input bit wr, input logic [23:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output logic [63:0] fr, output int nsck,
                          output int lat, output bit pulse_ok, output bit ok);
      int acc, t;
      ok = 1; rd = 'x; fr = 'x; nsck = -1; lat = -1; pulse_ok = 0;
      wait_ready();
      frames.delete();
      req_valid = 1; req_write = wr; req_addr = a; req_wdata = wd;
      @(negedge clk);
      acc = cyc;
      req_valid = 0; req_write = ~wr; req_addr = 24'($urandom); req_wdata = $urandom;
      t = 0;
      while (!resp_valid && t < 2000) begin @(negedge clk); t++; end
      if (!resp_valid) begin ok = 0; return; end
      lat = cyc - acc + 1;
      rd  = resp_rdata;
      @(negedge clk);
      pulse_ok = !resp_valid;
      if (frames.size() > 0) begin fr = frames[0].bits; nsck = frames[0].nsck; end
      else ok = 0;
   endtask

   task automatic check_txn(input string tag, input bit wr, input logic [23:0] a,
                            input logic [31:0] wd, input logic [31:0] exp_rd, input logic [63:0] exp_fr);
      logic [31:0] rd; logic [63:0] fr; int nsck, lat; bit pulse_ok, ok;
      run_txn(wr, a, wd, rd, fr, nsck, lat, pulse_ok, ok);
      check({tag, "_done"},  64'(ok), 64'd1);
      check({tag, "_rdata"}, 64'(rd), 64'(exp_rd));
      check({tag, "_mosi"},  fr, exp_fr);
      check({tag, "_sck"},   64'(nsck), 64'd64);
      check({tag, "_lat"},   64'(lat), 64'(LAT));
      check({tag, "_pulse"}, 64'(pulse_ok), 64'd1);
   endtask

   typedef struct {
      bit          wr;
      logic [23:0] addr;
      logic [31:0] wdata;
      logic [31:0] exp_rdata;
      logic [63:0] exp_frame;
   } vec_t;

   vec_t        vecs [6];
   logic [31:0] last_rd, v;
   logic [23:0] a;
   bit          wr, seen_ready;
   int          t, acc1, r1, acc2, cs_hi, viol;

   initial begin
      vecs[0] = '{1'b0, 24'h000104, 32'h0,        32'hDEADBEEF, 64'h03000104_00000000};
      vecs[1] = '{1'b1, 24'h00ABCD, 32'h12345678, 32'hDEADBEEF, 64'h0200ABCD_78563412};
      vecs[2] = '{1'b0, 24'h00ABCD, 32'h0,        32'h12345678, 64'h0300ABCD_00000000};
      vecs[3] = '{1'b0, 24'hFFFFFC, 32'h0,        32'h44332211, 64'h03FFFFFC_00000000};
      vecs[4] = '{1'b1, 24'hFFFFFE, 32'hCAFEF00D, 32'h44332211, 64'h02FFFFFE_0DF0FECA};
      vecs[5] = '{1'b0, 24'hFFFFFE, 32'h0,        32'hCAFEF00D, 64'h03FFFFFE_00000000};
      preload(24'h000104, 32'hDEADBEEF);
      preload(24'hFFFFFC, 32'h44332211);

      reset = 1; req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
      repeat (3) @(negedge clk);
      check("rst_cs", 64'(spi_cs), 64'd1);
      check("rst_sck", 64'(spi_sck), 64'd0);
      check("rst_mosi", 64'(spi_mosi), 64'd0);
      check("rst_ready_busy", {62'd0, req_ready, busy}, 64'b10);
      check("rst_resp", {31'd0, resp_valid, resp_rdata}, 64'd0);
      reset = 0;
      @(negedge clk);

      // Fixed vectors: documented load/store, read-back, 24-bit address wrap.
      for (int i = 0; i < 6; i++) begin
         check_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].addr, vecs[i].wdata,
                   vecs[i].exp_rdata, vecs[i].exp_frame);
         if (vecs[i].wr) ref_store(vecs[i].addr, vecs[i].wdata);
      end
      check("store_bytes", 64'({sram_rd(24'h00ABD0), sram_rd(24'h00ABCF),
                                sram_rd(24'h00ABCE), sram_rd(24'h00ABCD)}), 64'h12345678);
      last_rd = 32'hCAFEF00D;

      // Back-to-back store then load with req_valid held high.
      v = $urandom;
      wait_ready();
      frames.delete();
      req_valid = 1; req_write = 1; req_addr = 24'h000F00; req_wdata = v;
      @(negedge clk);
      acc1 = cyc;
      req_write = 0; req_wdata = $urandom;
      t = 0;
      while (!resp_valid && t < 2000) begin @(negedge clk); t++; end
      r1 = cyc + 1;
      cs_hi = 0; seen_ready = 0; acc2 = -1; t = 0;
      while (t < 2000) begin
         if (spi_cs) cs_hi++;
         if (req_ready) seen_ready = 1;
         else if (seen_ready) begin acc2 = cyc; break; end
         @(negedge clk); t++;
      end
      req_valid = 0;
      check("b2b_first_lat", 64'(r1 - acc1), 64'(LAT));
      check("b2b_gap", 64'(acc2 - r1), 64'(CS_GAP));
      check("b2b_cs_high", 64'(cs_hi >= 2), 64'd1);
      t = 0;
      while (!resp_valid && t < 2000) begin @(negedge clk); t++; end
      check("b2b_readback", 64'(resp_rdata), 64'(v));
      @(negedge clk);
      check("b2b_frames", 64'(frames.size()), 64'd2);
      ref_store(24'h000F00, v);
      last_rd = v;

      // req_valid pulsed mid-frame is ignored.
      wait_ready();
      frames.delete();
      req_valid = 1; req_write = 0; req_addr = 24'h000104;
      @(negedge clk);
      req_valid = 0;
      repeat (50) @(negedge clk);
      req_valid = 1; req_write = 1; req_addr = 24'h000104; req_wdata = 32'h0BADF00D;
      @(negedge clk);
      req_valid = 0;
      t = 0;
      while (!resp_valid && t < 2000) begin @(negedge clk); t++; end
      check("ign_rdata", 64'(resp_rdata), 64'hDEADBEEF);
      repeat (20) @(negedge clk);
      check("ign_frames", 64'(frames.size()), 64'd1);
      check("ign_sck", 64'(frames.size() > 0 ? frames[0].nsck : -1), 64'd64);
      check("ign_ready", 64'(req_ready), 64'd1);
      last_rd = 32'hDEADBEEF;

      // Asynchronous reset in the middle of a load.
      wait_ready();
      req_valid = 1; req_write = 0; req_addr = 24'h000104;
      @(negedge clk);
      req_valid = 0;
      t = 0;
      while (nbits < 20 && t < 1000) begin @(negedge clk); t++; end
      #1 reset = 1;
      #1;
      check("mid_rst_pins", {61'd0, spi_cs, spi_sck, spi_mosi}, 64'b100);
      check("mid_rst_ready", 64'(req_ready), 64'd1);
      check("mid_rst_rdata", 64'(resp_rdata), 64'd0);
      @(negedge clk); @(negedge clk);
      reset = 0;
      viol = 0;
      repeat (300) begin @(negedge clk); if (resp_valid) viol++; end
      check("mid_rst_no_resp", 64'(viol), 64'd0);
      check_txn("after_rst", 1'b0, 24'h000104, 32'h0, 32'hDEADBEEF, 64'h03000104_00000000);
      last_rd = 32'hDEADBEEF;

      // Random traffic against the reference memory.
      for (int i = 0; i < 16; i++) begin
         wr = 1'($urandom_range(0, 1));
         a  = 24'h200000 + 24'($urandom_range(0, 31));
         v  = $urandom;
         if (wr) begin
            check_txn($sformatf("rnd%0d_st", i), 1'b1, a, v, last_rd, exp_frame(1'b1, a, v));
            ref_store(a, v);
         end else begin
            check_txn($sformatf("rnd%0d_ld", i), 1'b0, a, v, ref_load(a), exp_frame(1'b0, a, v));
            last_rd = ref_load(a);
         end
      end

      // Idle: bus quiet, no responses.
      wait_ready();
      viol = 0;
      repeat (100) begin
         @(negedge clk);
         if (!spi_cs || spi_sck || resp_valid) viol++;
      end
      check("idle_quiet", 64'(viol), 64'd0);
      check("sck_while_cs_high", 64'(sck_cs_viol), 64'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
